// File: rtl/pwm_wb_pkg.sv
// Shared types and constants for the PWM Wishbone arbiter and splitter-side arbiters.
package pwm_wb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StOwn0  = 2'd1,
      StOwn1  = 2'd2,
      StAbort = 2'd3
   } state_e;

   // One-hot owner encoding as seen on grant_o
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/pwm_wb_rr_pick.sv
// Two-input round-robin picker: one-hot grant from req[1:0]; ties go to the master that
// was not granted last. Purely combinational.
module pwm_wb_rr_pick
   import pwm_wb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,   // 0: m0 was granted last, 1: m1 was granted last
   output logic [1:0] grant_o
);

   // Single requester wins outright; a tie alternates against last_i
   always_comb begin
      grant_o = GRANT_NONE;
      unique case (req_i)
         2'b01:   grant_o = GRANT_M0;
         2'b10:   grant_o = GRANT_M1;
         2'b11:   grant_o = last_i ? GRANT_M0 : GRANT_M1;
         default: grant_o = GRANT_NONE;
      endcase
   end

endmodule

// File: rtl/pwm_wb_arbiter.sv
// Two-master Wishbone B4 classic arbiter in front of the PWM timer bus splitter.
// m0 = Caravel host, m1 = on-chip sequencer. Round-robin, locked for the owner's cyc.
// Optional stuck-slave timeout: define PWM_WB_ARB_TIMEOUT_EN.
module pwm_wb_arbiter
   import pwm_wb_pkg::*;
#(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      grant_o
);

   localparam int unsigned SW = DW / 8;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("pwm_wb_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

   state_e state_q, state_d;
   logic   last_q, last_d;   // 1: m1 was granted last
   logic [1:0] pick;

   logic          own_cyc, own_stb, own_we;
   logic [SW-1:0] own_sel;
   logic [AW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic          timeout_hit;
   logic          term_ack, term_err;

   pwm_wb_rr_pick u_pick (
      .req_i   ({m1_cyc_i, m0_cyc_i}),
      .last_i  (last_q),
      .grant_o (pick)
   );

   // Select the owning master's request; zero when nobody owns the bus (incl. abort)
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_sel = '0;
      own_adr = '0;
      own_dat = '0;
      unique case (state_q)
         StOwn0: begin
            own_cyc = m0_cyc_i;
            own_stb = m0_cyc_i & m0_stb_i;
            own_we  = m0_we_i;
            own_sel = m0_sel_i;
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
         end
         StOwn1: begin
            own_cyc = m1_cyc_i;
            own_stb = m1_cyc_i & m1_stb_i;
            own_we  = m1_we_i;
            own_sel = m1_sel_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
         end
         default: ;
      endcase
   end

`ifdef PWM_WB_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count stalled strobe cycles; the last stalled cycle is turned into an error beat
   always_comb begin
      cnt_d       = '0;
      timeout_hit = 1'b0;
      if (own_stb && !s_ack_i && !s_err_i) begin
         if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Stall counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Drive the slave from the owner and route its termination back to the owner only
   always_comb begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb & ~timeout_hit;
      s_we_o   = own_we;
      s_sel_o  = own_sel;
      s_adr_o  = own_adr;
      s_dat_o  = own_dat;
      // err has priority over a simultaneous ack
      term_ack = s_ack_i & s_stb_o & ~s_err_i;
      term_err = (s_err_i & s_stb_o) | timeout_hit;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_dat_o = '0;
      grant_o  = GRANT_NONE;
      unique case (state_q)
         StOwn0: begin
            m0_ack_o = term_ack;
            m0_err_o = term_err;
            m0_dat_o = s_dat_i;
            grant_o  = GRANT_M0;
         end
         StOwn1: begin
            m1_ack_o = term_ack;
            m1_err_o = term_err;
            m1_dat_o = s_dat_i;
            grant_o  = GRANT_M1;
         end
         default: ;
      endcase
   end

   // Next-state: arbitrate only from idle, release when the owner drops cyc
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (pick == GRANT_M0) begin
               state_d = StOwn0;
               last_d  = 1'b0;
            end else if (pick == GRANT_M1) begin
               state_d = StOwn1;
               last_d  = 1'b1;
            end
         end
         StOwn0: begin
            if (!m0_cyc_i) begin
               state_d = StIdle;
            end else if (timeout_hit) begin
               state_d = StAbort;
            end
         end
         StOwn1: begin
            if (!m1_cyc_i) begin
               state_d = StIdle;
            end else if (timeout_hit) begin
               state_d = StAbort;
            end
         end
         StAbort: begin
            // last_q still names the aborted owner
            if (!(last_q ? m1_cyc_i : m0_cyc_i)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and round-robin history registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule
